cnn_frame_sequencer: RTL and testbench

Controller that sequences the simpleCNN datapath across a stream of images. Accepts image rows plus a per-image label on a valid/ready stream, pulses START, and drives row coordinates and row data into the CNN. It then waits for DONE, compares OUT against the label, and emits one result record per image with running image/error counters. It sits between the image/label source and simpleCNN, replacing bench-driven START/X/Y/IMGIN sequencing.

---
 rtl/cnn_pkg.sv | 22 ++
 rtl/cnn_frame_sequencer_if.sv | 39 +++
 rtl/sat_counter.sv | 25 ++
 rtl/cnn_frame_sequencer.sv | 156 +++++++++++++++
 tb/tb_cnn_frame_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN frame sequencer.
package cnn_pkg;

  localparam int unsigned CLASS_W = 4;
  localparam int unsigned XY_W    = 5;
  localparam logic [CLASS_W-1:0] TIMEOUT_CLASS = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_LOAD,
    ST_WAIT,
    ST_REPORT
  } state_e;

  typedef struct packed {
    logic [CLASS_W-1:0] cls;
    logic               correct;
    logic               timeout;
  } res_t;

endpackage

// File: rtl/cnn_frame_sequencer_if.sv
// Row-source, CNN and result-consumer signals seen by the frame sequencer.
interface cnn_frame_sequencer_if #(
  parameter int unsigned ROW_W = 200,
  parameter int unsigned CNT_W = 16
) ();

  logic                        EN;
  logic                        ROW_VALID;
  logic                        ROW_READY;
  logic [ROW_W-1:0]            ROW_DATA;
  logic [cnn_pkg::CLASS_W-1:0] ROW_LABEL;
  logic                        CNN_START;
  logic [cnn_pkg::XY_W-1:0]    CNN_X;
  logic [cnn_pkg::XY_W-1:0]    CNN_Y;
  logic [ROW_W-1:0]            CNN_IMGIN;
  logic                        CNN_ROW_VALID;
  logic                        CNN_DONE;
  logic [cnn_pkg::CLASS_W-1:0] CNN_OUT;
  logic                        RES_VALID;
  logic                        RES_READY;
  logic [cnn_pkg::CLASS_W-1:0] RES_CLASS;
  logic                        RES_CORRECT;
  logic                        RES_TIMEOUT;
  logic [CNT_W-1:0]            IMG_CNT;
  logic [CNT_W-1:0]            ERR_CNT;

  modport master (
    input  EN, ROW_VALID, ROW_DATA, ROW_LABEL, CNN_DONE, CNN_OUT, RES_READY,
    output ROW_READY, CNN_START, CNN_X, CNN_Y, CNN_IMGIN, CNN_ROW_VALID,
           RES_VALID, RES_CLASS, RES_CORRECT, RES_TIMEOUT, IMG_CNT, ERR_CNT
  );

  modport slave (
    output EN, ROW_VALID, ROW_DATA, ROW_LABEL, CNN_DONE, CNN_OUT, RES_READY,
    input  ROW_READY, CNN_START, CNN_X, CNN_Y, CNN_IMGIN, CNN_ROW_VALID,
           RES_VALID, RES_CLASS, RES_CORRECT, RES_TIMEOUT, IMG_CNT, ERR_CNT
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !(&cnt_q)) cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cnn_frame_sequencer.sv
// Sequences image rows into the CNN, waits for its class and reports
// one scored result per image with running image/error counts.
module cnn_frame_sequencer
  import cnn_pkg::*;
#(
  parameter int unsigned ROW_W   = 200,
  parameter int unsigned ROWS    = 28,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  cnn_frame_sequencer_if.master bus
);

  localparam int unsigned ROW_CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned TMO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e               state_q, state_d;
  logic [ROW_CNT_W-1:0] row_cnt_q, row_cnt_d;
  logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [CLASS_W-1:0]   label_q, label_d;
  logic [ROW_W-1:0]     imgin_q, imgin_d;
  logic [XY_W-1:0]      y_q, y_d;
  logic [XY_W-1:0]      x_q, x_d;
  res_t                 res_q, res_d;
  logic                 start_q, start_d;
  logic                 ready_q, ready_d;
  logic                 row_valid_q, row_valid_d;
  logic                 res_valid_q, res_valid_d;
  logic                 img_inc_c, err_inc_c, row_acc_c;

  assign row_acc_c = bus.ROW_VALID & ready_q;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    label_d     = label_q;
    imgin_d     = imgin_q;
    y_d         = y_q;
    x_d         = x_q;
    res_d       = res_q;
    row_valid_d = 1'b0;
    img_inc_c   = 1'b0;
    err_inc_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.EN) state_d = ST_START;
      end
      ST_START: begin
        row_cnt_d = '0;
        state_d   = ST_LOAD;
      end
      ST_LOAD: begin
        if (row_acc_c) begin
          imgin_d     = bus.ROW_DATA;
          y_d         = XY_W'(row_cnt_q);
          row_valid_d = 1'b1;
          row_cnt_d   = row_cnt_q + ROW_CNT_W'(1);
          if (row_cnt_q == '0) label_d = bus.ROW_LABEL;
          if (row_cnt_q == ROW_CNT_W'(ROWS - 1)) begin
            tmo_cnt_d = '0;
            state_d   = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        // A DONE arriving on the expiry cycle still counts as a real result.
        if (bus.CNN_DONE) begin
          res_d.cls     = bus.CNN_OUT;
          res_d.correct = (bus.CNN_OUT == label_q);
          res_d.timeout = 1'b0;
          state_d       = ST_REPORT;
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
          res_d.cls     = TIMEOUT_CLASS;
          res_d.correct = 1'b0;
          res_d.timeout = 1'b1;
          state_d       = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (bus.RES_READY) begin
          img_inc_c = 1'b1;
          err_inc_c = ~res_q.correct;
          x_d       = x_q + XY_W'(1);
          state_d   = bus.EN ? ST_START : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    start_d     = (state_d == ST_START);
    ready_d     = (state_d == ST_LOAD);
    res_valid_d = (state_d == ST_REPORT);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      row_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      label_q     <= '0;
      imgin_q     <= '0;
      y_q         <= '0;
      x_q         <= '0;
      res_q       <= '0;
      start_q     <= 1'b0;
      ready_q     <= 1'b0;
      row_valid_q <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      label_q     <= label_d;
      imgin_q     <= imgin_d;
      y_q         <= y_d;
      x_q         <= x_d;
      res_q       <= res_d;
      start_q     <= start_d;
      ready_q     <= ready_d;
      row_valid_q <= row_valid_d;
      res_valid_q <= res_valid_d;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_img_cnt (
    .clk_i (CLK),
    .clr_i (RST),
    .inc_i (img_inc_c),
    .cnt_o (bus.IMG_CNT)
  );

  sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
    .clk_i (CLK),
    .clr_i (RST),
    .inc_i (err_inc_c),
    .cnt_o (bus.ERR_CNT)
  );

  assign bus.ROW_READY     = ready_q;
  assign bus.CNN_START     = start_q;
  assign bus.CNN_X         = x_q;
  assign bus.CNN_Y         = y_q;
  assign bus.CNN_IMGIN     = imgin_q;
  assign bus.CNN_ROW_VALID = row_valid_q;
  assign bus.RES_VALID     = res_valid_q;
  assign bus.RES_CLASS     = res_q.cls;
  assign bus.RES_CORRECT   = res_q.correct;
  assign bus.RES_TIMEOUT   = res_q.timeout;

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Directed bench for cnn_frame_sequencer: reset, single image, row gaps,
// backpressure, timeout and slot-index wrap over a 33-image stream.
module tb_cnn_frame_sequencer;

  localparam int unsigned ROW_W      = 200;
  localparam int unsigned ROWS       = 28;
  localparam int unsigned TB_TIMEOUT = 64;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned B2B_LAT    = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cnn_frame_sequencer_if #(.ROW_W(ROW_W), .CNT_W(CNT_W)) bus ();

  cnn_frame_sequencer #(
    .ROW_W   (ROW_W),
    .ROWS    (ROWS),
    .TIMEOUT (TB_TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor state
  int               cyc = 0;
  int               start_cnt = 0;
  int               start_wide_err = 0;
  int               rows_seen = 0;
  int               y_err = 0;
  int               data_err = 0;
  int               rv_err = 0;
  int               hold_err = 0;
  int               img_id = 0;
  logic [4:0]       exp_y = '0;
  logic             acc_prev = 1'b0;
  logic             start_prev = 1'b0;
  logic             rst_prev = 1'b1;
  logic [4:0]       y_prev = '0;
  logic [ROW_W-1:0] img_prev = '0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] row_pat(input int img, input int r);
    logic [7:0] b;
    b = 8'(img * 29 + r * 3 + 1);
    return {25{b}};
  endfunction

  // CNN-side observer: row order, data, one-cycle latency, hold, start pulse width.
  always @(negedge clk) begin
    cyc++;
    if (!rst && !rst_prev) begin
      if (bus.CNN_START) begin
        start_cnt++;
        if (start_prev) start_wide_err++;
        exp_y = '0;
      end
      if (bus.CNN_ROW_VALID !== acc_prev) rv_err++;
      if (bus.CNN_ROW_VALID) begin
        rows_seen++;
        if (bus.CNN_Y !== exp_y) y_err++;
        if (bus.CNN_IMGIN !== row_pat(img_id, int'(exp_y))) data_err++;
        exp_y = exp_y + 5'd1;
      end else if (bus.CNN_Y !== y_prev || bus.CNN_IMGIN !== img_prev) begin
        hold_err++;
      end
    end
    acc_prev   = bus.ROW_VALID & bus.ROW_READY & !rst;
    start_prev = bus.CNN_START;
    rst_prev   = rst;
    y_prev     = bus.CNN_Y;
    img_prev   = bus.CNN_IMGIN;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_image(input int img, input logic [3:0] label, input bit gap,
                            input bit drop_en, input int nrows);
    int n;
    bit ok;
    img_id = img;
    for (int r = 0; r < nrows; r++) begin
      n  = 0;
      ok = 1'b0;
      bus.ROW_VALID = 1'b1;
      bus.ROW_DATA  = row_pat(img, r);
      bus.ROW_LABEL = (r == 0) ? label : (label ^ 4'hA);
      while (!ok && n < 200) begin
        ok = bus.ROW_READY;
        tick();
        n++;
      end
      if (!ok) check("row_accept_timeout", 0, 1);
      if (drop_en && r == 0) bus.EN = 1'b0;
      if (gap && r != nrows - 1) begin
        bus.ROW_VALID = 1'b0;
        bus.ROW_DATA  = ~row_pat(img, r);
        tick();
      end
    end
    bus.ROW_VALID = 1'b0;
    bus.ROW_DATA  = '0;
  endtask

  task automatic done_after(input int lat, input logic [3:0] cls);
    repeat (lat) tick();
    bus.CNN_DONE = 1'b1;
    bus.CNN_OUT  = cls;
    tick();
    bus.CNN_DONE = 1'b0;
    bus.CNN_OUT  = 4'h0;
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (!bus.RES_VALID && n < 500) begin
      tick();
      n++;
    end
    if (!bus.RES_VALID) check("res_valid_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int s0;
    int t_prev;
    rst           = 1'b1;
    bus.EN        = 1'b0;
    bus.ROW_VALID = 1'b0;
    bus.ROW_DATA  = '0;
    bus.ROW_LABEL = '0;
    bus.CNN_DONE  = 1'b0;
    bus.CNN_OUT   = '0;
    bus.RES_READY = 1'b1;
    t_prev        = 0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_row_ready", bus.ROW_READY, 0);
    check("rst_start", bus.CNN_START, 0);
    check("rst_x", bus.CNN_X, 0);
    check("rst_y", bus.CNN_Y, 0);
    check("rst_imgin", bus.CNN_IMGIN, 0);
    check("rst_row_valid", bus.CNN_ROW_VALID, 0);
    check("rst_res_valid", bus.RES_VALID, 0);
    check("rst_res_class", bus.RES_CLASS, 0);
    check("rst_res_correct", bus.RES_CORRECT, 0);
    check("rst_res_timeout", bus.RES_TIMEOUT, 0);
    check("rst_img_cnt", bus.IMG_CNT, 0);
    check("rst_err_cnt", bus.ERR_CNT, 0);

    // DONE while idle is ignored
    bus.CNN_DONE = 1'b1;
    bus.CNN_OUT  = 4'h3;
    tick();
    bus.CNN_DONE = 1'b0;
    repeat (3) tick();
    check("idle_done_res_valid", bus.RES_VALID, 0);
    check("idle_done_img_cnt", bus.IMG_CNT, 0);

    // Reset in the middle of LOAD (after 10 rows)
    bus.EN = 1'b1;
    send_image(0, 4'h1, 1'b0, 1'b0, 10);
    check("pre_reset_y", bus.CNN_Y, 9);
    rst    = 1'b1;
    bus.EN = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    check("midrst_y", bus.CNN_Y, 0);
    check("midrst_imgin", bus.CNN_IMGIN, 0);
    check("midrst_row_ready", bus.ROW_READY, 0);
    check("midrst_row_valid", bus.CNN_ROW_VALID, 0);
    check("midrst_res_valid", bus.RES_VALID, 0);
    check("midrst_img_cnt", bus.IMG_CNT, 0);
    s0 = start_cnt;
    repeat (3) tick();
    check("midrst_idle_ready", bus.ROW_READY, 0);
    check("midrst_idle_nostart", start_cnt - s0, 0);

    // Single image, label 7, DONE 50 cycles after last row; EN drops mid-image
    s0        = start_cnt;
    rows_seen = 0;
    bus.EN    = 1'b1;
    send_image(1, 4'h7, 1'b0, 1'b1, ROWS);
    check("last_row_ready_drop", bus.ROW_READY, 0);
    done_after(49, 4'h7);
    wait_result(n);
    check("single_class", bus.RES_CLASS, 7);
    check("single_correct", bus.RES_CORRECT, 1);
    check("single_timeout", bus.RES_TIMEOUT, 0);
    check("single_x", bus.CNN_X, 0);
    check("single_starts", start_cnt - s0, 1);
    check("single_rows", rows_seen, ROWS);
    tick();
    check("single_img_cnt", bus.IMG_CNT, 1);
    check("single_err_cnt", bus.ERR_CNT, 0);
    check("single_x_inc", bus.CNN_X, 1);
    check("single_res_valid_drop", bus.RES_VALID, 0);
    repeat (3) tick();
    check("single_en_off_idle", start_cnt - s0, 1);

    // Row gaps every other cycle
    rows_seen = 0;
    bus.EN    = 1'b1;
    send_image(2, 4'h2, 1'b1, 1'b1, ROWS);
    done_after(5, 4'h2);
    wait_result(n);
    check("gap_rows", rows_seen, ROWS);
    check("gap_class", bus.RES_CLASS, 2);
    check("gap_correct", bus.RES_CORRECT, 1);
    tick();
    check("gap_img_cnt", bus.IMG_CNT, 2);

    // Mismatch with 4 cycles of result backpressure
    bus.EN        = 1'b1;
    bus.RES_READY = 1'b0;
    send_image(3, 4'h3, 1'b0, 1'b1, ROWS);
    done_after(2, 4'h5);
    wait_result(n);
    for (int k = 0; k < 4; k++) begin
      check("bp_res_valid", bus.RES_VALID, 1);
      check("bp_class", bus.RES_CLASS, 5);
      check("bp_correct", bus.RES_CORRECT, 0);
      check("bp_err_hold", bus.ERR_CNT, 0);
      tick();
    end
    check("bp_still_valid", bus.RES_VALID, 1);
    bus.RES_READY = 1'b1;
    tick();
    check("bp_err_cnt", bus.ERR_CNT, 1);
    check("bp_img_cnt", bus.IMG_CNT, 3);
    check("bp_res_valid_drop", bus.RES_VALID, 0);

    // Timeout with no DONE
    bus.EN = 1'b1;
    send_image(4, 4'h4, 1'b0, 1'b1, ROWS);
    wait_result(n);
    check("tmo_latency", n, TB_TIMEOUT);
    check("tmo_class", bus.RES_CLASS, 4'hF);
    check("tmo_flag", bus.RES_TIMEOUT, 1);
    check("tmo_correct", bus.RES_CORRECT, 0);
    tick();
    check("tmo_err_cnt", bus.ERR_CNT, 2);
    check("tmo_img_cnt", bus.IMG_CNT, 4);

    // DONE on the last timeout cycle wins
    bus.EN = 1'b1;
    send_image(5, 4'h6, 1'b0, 1'b1, ROWS);
    done_after(TB_TIMEOUT - 1, 4'h6);
    wait_result(n);
    check("edge_wait", n, 0);
    check("edge_timeout", bus.RES_TIMEOUT, 0);
    check("edge_class", bus.RES_CLASS, 6);
    check("edge_correct", bus.RES_CORRECT, 1);
    tick();
    check("edge_err_cnt", bus.ERR_CNT, 2);
    check("edge_img_cnt", bus.IMG_CNT, 5);

    // 33 back-to-back images: slot index wraps, DONE before START ignored
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    bus.CNN_DONE = 1'b1;
    bus.CNN_OUT  = 4'h1;
    tick();
    bus.CNN_DONE = 1'b0;
    tick();
    bus.EN        = 1'b1;
    bus.RES_READY = 1'b1;
    for (int i = 0; i < 33; i++) begin
      send_image(100 + i, 4'(i % 10), 1'b0, (i == 32), ROWS);
      done_after(B2B_LAT, 4'(i % 10));
      wait_result(n);
      check("wrap_x", bus.CNN_X, i % 32);
      if (i > 0) check("b2b_period", cyc - t_prev, ROWS + 2 + B2B_LAT + 1);
      t_prev = cyc;
    end
    tick();
    check("wrap_img_cnt", bus.IMG_CNT, 33);
    check("wrap_err_cnt", bus.ERR_CNT, 0);
    check("wrap_x_final", bus.CNN_X, 1);

    // Observer totals
    check("mon_y_order", y_err, 0);
    check("mon_row_data", data_err, 0);
    check("mon_row_valid_latency", rv_err, 0);
    check("mon_hold", hold_err, 0);
    check("mon_start_width", start_wide_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
